// File: rtl/rx_ctrl_pkg.sv
// Shared receiver-control definitions: sequencer state encodings and the
// slicer-error magnitude width helper.
package rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_ACQ    = 3'd2,
    ST_TRACK  = 3'd3,
    ST_FREEZE = 3'd4
  } fse_state_e;

  // |eI|+|eQ| needs one bit more than a single error sample.
  localparam int unsigned MAG_GROWTH = 1;

  function automatic int unsigned mag_width(input int unsigned nbt_err);
    return nbt_err + MAG_GROWTH;
  endfunction

endpackage

// File: rtl/fse_adapt_ctrl_err_mag_window.sv
// Windowed |eI|+|eQ| detector: saturating abs, per-window accumulator and
// threshold compare; done/good/bad are single-cycle pulses on the closing strobe.
module err_mag_window #(
  parameter int unsigned NBT_ERR    = 12,
  parameter int unsigned LOG2_WIN   = 8,
  parameter logic [11:0] LOCK_THR   = 12'd96,
  parameter logic [11:0] UNLOCK_THR = 12'd160
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      i_clear,
  input  logic                      i_run,
  input  logic                      i_sym_valid,
  input  logic signed [NBT_ERR-1:0] i_err_I,
  input  logic signed [NBT_ERR-1:0] i_err_Q,
  output logic                      o_win_done,
  output logic                      o_win_good,
  output logic                      o_win_bad
);
  import rx_ctrl_pkg::*;

  localparam int unsigned MW = mag_width(NBT_ERR);
  localparam int unsigned AW = MW + LOG2_WIN;
  localparam logic [AW-1:0] LOCK_LIM   = AW'(LOCK_THR) << LOG2_WIN;
  localparam logic [AW-1:0] UNLOCK_LIM = AW'(UNLOCK_THR) << LOG2_WIN;
  localparam logic [NBT_ERR-1:0] SMIN = {1'b1, {(NBT_ERR-1){1'b0}}};
  localparam logic [NBT_ERR-1:0] SMAX = {1'b0, {(NBT_ERR-1){1'b1}}};

  function automatic logic [NBT_ERR-1:0] sat_abs(input logic signed [NBT_ERR-1:0] e);
    if ($unsigned(e) == SMIN) return SMAX;
    else if (e[NBT_ERR-1])    return $unsigned(-e);
    else                      return $unsigned(e);
  endfunction

  logic [AW-1:0]       r_acc;
  logic [LOG2_WIN-1:0] r_cnt;
  logic [MW-1:0]       w_mag;
  logic [AW-1:0]       w_acc_sum;
  logic                w_step;
  logic                w_last;

  assign w_mag     = MW'(sat_abs(i_err_I)) + MW'(sat_abs(i_err_Q));
  assign w_step    = i_run & i_sym_valid;
  assign w_last    = (r_cnt == '1);
  assign w_acc_sum = r_acc + AW'(w_mag);

  // The closing strobe's magnitude is part of the evaluated window.
  assign o_win_done = w_step & w_last;
  assign o_win_good = o_win_done & (w_acc_sum <= LOCK_LIM);
  assign o_win_bad  = o_win_done & (w_acc_sum > UNLOCK_LIM);

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_acc <= w_last ? '0 : w_acc_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fse_adapt_ctrl.sv
// FSE/LMS adaptation sequencer: flush, large-step acquisition, small-step
// tracking with windowed lock detection, and freeze/restart handling.
module fse_adapt_ctrl #(
  parameter int unsigned NBT_ERR      = 12,
  parameter int unsigned NBT_LMS_STEP = 12,
  parameter int unsigned NBT_LMS_LEAK = 11,
  parameter logic signed [NBT_LMS_STEP-1:0] STEP_ACQ = 12'sh010,
  parameter logic signed [NBT_LMS_STEP-1:0] STEP_TRK = 12'sh001,
  parameter logic signed [NBT_LMS_LEAK-1:0] LMS_LEAK = 11'sh001,
  parameter int unsigned FLUSH_CYC    = 22,
  parameter int unsigned ACQ_SYMS     = 4096,
  parameter int unsigned LOG2_WIN     = 8,
  parameter logic [11:0] LOCK_THR     = 12'd96,
  parameter logic [11:0] UNLOCK_THR   = 12'd160,
  parameter int unsigned LOSS_WINDOWS = 2
) (
  input  logic                           clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_freeze,
  input  logic                           i_sym_valid,
  input  logic signed [NBT_ERR-1:0]      i_err_I,
  input  logic signed [NBT_ERR-1:0]      i_err_Q,
  output logic                           o_flush,
  output logic                           o_lms_en,
  output logic signed [NBT_LMS_STEP-1:0] o_lms_step,
  output logic signed [NBT_LMS_LEAK-1:0] o_lms_leak,
  output logic                           o_locked,
  output logic [2:0]                     o_state
);
  import rx_ctrl_pkg::*;

  localparam int unsigned FCW = $clog2(FLUSH_CYC + 1);
  localparam int unsigned ACW = $clog2(ACQ_SYMS + 1);
  localparam int unsigned MSW = $clog2(LOSS_WINDOWS + 1);

  typedef struct packed {
    logic                           en;
    logic signed [NBT_LMS_STEP-1:0] step;
    logic signed [NBT_LMS_LEAK-1:0] leak;
  } adapt_t;

  function automatic adapt_t adapt_for(input fse_state_e s);
    adapt_t a;
    a = '0;
    if (s == ST_ACQ)        a = '{en: 1'b1, step: STEP_ACQ, leak: LMS_LEAK};
    else if (s == ST_TRACK) a = '{en: 1'b1, step: STEP_TRK, leak: LMS_LEAK};
    return a;
  endfunction

  fse_state_e     r_state;
  fse_state_e     r_ret;
  adapt_t         r_adapt;
  logic           r_flush;
  logic           r_locked;
  logic [FCW-1:0] r_flush_cnt;
  logic [ACW-1:0] r_acq_cnt;
  logic [MSW-1:0] r_miss;

  logic w_run;
  logic w_win_done;
  logic w_win_good;
  logic w_win_bad;

  // Strobes arriving while a freeze or restart takes effect are not counted.
  assign w_run = ((r_state == ST_ACQ) || (r_state == ST_TRACK)) && !i_freeze && !i_start;

  err_mag_window #(
    .NBT_ERR    (NBT_ERR),
    .LOG2_WIN   (LOG2_WIN),
    .LOCK_THR   (LOCK_THR),
    .UNLOCK_THR (UNLOCK_THR)
  ) u_win (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_clear     (i_start),
    .i_run       (w_run),
    .i_sym_valid (i_sym_valid),
    .i_err_I     (i_err_I),
    .i_err_Q     (i_err_Q),
    .o_win_done  (w_win_done),
    .o_win_good  (w_win_good),
    .o_win_bad   (w_win_bad)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_ret       <= ST_IDLE;
      r_adapt     <= '0;
      r_flush     <= 1'b0;
      r_locked    <= 1'b0;
      r_flush_cnt <= '0;
      r_acq_cnt   <= '0;
      r_miss      <= '0;
    end else if (i_start) begin
      r_state     <= ST_FLUSH;
      r_ret       <= ST_IDLE;
      r_adapt     <= adapt_for(ST_FLUSH);
      r_flush     <= 1'b1;
      r_locked    <= 1'b0;
      r_flush_cnt <= '0;
      r_acq_cnt   <= '0;
      r_miss      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_FLUSH: begin
          if (r_flush_cnt == FCW'(FLUSH_CYC - 1)) begin
            r_state     <= ST_ACQ;
            r_adapt     <= adapt_for(ST_ACQ);
            r_flush     <= 1'b0;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        ST_ACQ, ST_TRACK: begin
          if (i_freeze) begin
            r_ret   <= r_state;
            r_state <= ST_FREEZE;
            r_adapt <= adapt_for(ST_FREEZE);
          end else if (r_state == ST_ACQ) begin
            if (i_sym_valid) begin
              if (r_acq_cnt == ACW'(ACQ_SYMS - 1)) begin
                r_state   <= ST_TRACK;
                r_adapt   <= adapt_for(ST_TRACK);
                r_acq_cnt <= '0;
              end else begin
                r_acq_cnt <= r_acq_cnt + 1'b1;
              end
            end
          end else if (w_win_done) begin
            // Loss is taken on the bad window that would bring misses to LOSS_WINDOWS.
            if (!r_locked) begin
              if (w_win_good) begin
                r_locked <= 1'b1;
                r_miss   <= '0;
              end
            end else if (w_win_bad) begin
              if (r_miss == MSW'(LOSS_WINDOWS - 1)) begin
                r_locked  <= 1'b0;
                r_miss    <= '0;
                r_state   <= ST_ACQ;
                r_adapt   <= adapt_for(ST_ACQ);
                r_acq_cnt <= '0;
              end else begin
                r_miss <= r_miss + 1'b1;
              end
            end else begin
              r_miss <= '0;
            end
          end
        end
        ST_FREEZE: begin
          if (!i_freeze) begin
            r_state <= r_ret;
            r_adapt <= adapt_for(r_ret);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_adapt <= '0;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_flush    = r_flush;
  assign o_locked   = r_locked;
  assign o_lms_en   = r_adapt.en;
  assign o_lms_step = r_adapt.step;
  assign o_lms_leak = r_adapt.leak;

endmodule

// File: doc/fse_adapt_ctrl.md
# fse_adapt_ctrl

Adaptation sequencer for the receiver's fractionally-spaced equalizer (FSE) and its LMS tap-update engine. It sits beside the baud-rate downsampler and slicer. It drives the FSE flush, the LMS enable, and the step/leak values, and it runs a two-phase schedule: acquisition with a large step, then tracking with a small step. A windowed slicer-error magnitude detector declares lock, and loss of lock sends the sequencer back to acquisition.

## Interface
- NBT_ERR, 12, slicer error width (signed, same Q format as the tap error)
- NBT_LMS_STEP, 12, step output width
- NBT_LMS_LEAK, 11, leak output width
- STEP_ACQ, 12'sh010, step value during acquisition
- STEP_TRK, 12'sh001, step value during tracking
- LMS_LEAK, 11'sh001, leak value while adapting
- FLUSH_CYC, 22, number of clk cycles `o_flush` is held high
- ACQ_SYMS, 4096, number of symbols spent in ACQ
- LOG2_WIN, 8, lock window length = 2^LOG2_WIN symbols
- LOCK_THR, 12'd96, mean |eI|+|eQ| at or below this value declares lock
- UNLOCK_THR, 12'd160, mean above this value counts as a bad window
- LOSS_WINDOWS, 2, consecutive bad windows needed to drop lock
- clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  single-cycle pulse that (re)starts the schedule
- i_freeze  in  1  level signal that halts adaptation
- i_sym_valid  in  1  one-cycle strobe per baud, aligned with the slicer error
- i_err_I  in  NBT_ERR  signed slicer error, I branch
- i_err_Q  in  NBT_ERR  signed slicer error, Q branch
- o_flush  out  1  clears the FSE delay line and taps
- o_lms_en  out  1  tap-update enable
- o_lms_step  out  NBT_LMS_STEP  signed step value
- o_lms_leak  out  NBT_LMS_LEAK  signed leak value
- o_locked  out  1  lock indication
- o_state  out  3  current state

## Operation
- State encoding: IDLE=0, FLUSH=1, ACQ=2, TRACK=3, FREEZE=4.
- IDLE → FLUSH on `i_start`.
- FLUSH: `o_flush`=1 for exactly FLUSH_CYC cycles, then → ACQ.
- ACQ: `o_lms_en`=1, step=STEP_ACQ, leak=LMS_LEAK. Counts `i_sym_valid` strobes; on the ACQ_SYMS-th strobe → TRACK.
- TRACK: `o_lms_en`=1, step=STEP_TRK, leak=LMS_LEAK.
- Outside ACQ/TRACK: `o_lms_en`=0, step=0, leak=0.
- Magnitude per strobe: m = |eI| + |eQ|. Each abs saturates, so -2^(NBT_ERR-1) maps to 2^(NBT_ERR-1)-1. m is NBT_ERR+1 bits unsigned.
- Window accumulator: width NBT_ERR+1+LOG2_WIN. It runs in ACQ and TRACK only.
- Window end: on the 2^LOG2_WIN-th strobe, evaluate acc including the current m. The next window then starts from 0.
- Window comparisons are against thresholds shifted left by LOG2_WIN, so no divider is needed.
- In TRACK and not locked: if acc ≤ LOCK_THR<<LOG2_WIN, set `o_locked`=1 and clear the miss counter.
- While locked: if acc > UNLOCK_THR<<LOG2_WIN, increment the miss counter; otherwise clear it.
- When the miss counter reaches LOSS_WINDOWS: `o_locked`=0, → ACQ, ACQ counter cleared.
- ACQ windows are evaluated but cannot set lock.
- FREEZE: entered from ACQ or TRACK while `i_freeze`=1.
  - The return state, the ACQ counter, the window accumulator, the window count and `o_locked` are all held.
  - On `i_freeze`=0 → return state.
  - `i_freeze` in IDLE or FLUSH is ignored.
- `i_start` in any state restarts the schedule: → FLUSH, all counters cleared, `o_locked`=0.
- `i_start` takes priority over `i_freeze`.
- Window bookkeeping and state changes are evaluated in the same cycle. When the ACQ_SYMS-th strobe is also a window end, the window is evaluated as an ACQ window, and the next state is TRACK.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `o_flush`=0, `o_lms_en`=0, `o_lms_step`=0, `o_lms_leak`=0, `o_locked`=0, `o_state`=0. All counters are 0.
- Reset asserted mid-operation returns to these values immediately (asynchronous).
- `i_start` at cycle t → `o_state`=1 and `o_flush`=1 from t+1 through t+FLUSH_CYC. At t+FLUSH_CYC+1: `o_state`=2, `o_lms_en`=1.
- Strobe at cycle t that completes ACQ or a window → new state and new `o_locked` value visible at t+1.
- `i_freeze` high at t → `o_lms_en`=0 at t+1. `i_freeze` low at t → `o_lms_en`=1 at t+1.
- `i_sym_valid` is sampled every cycle. Back-to-back strobes are legal.

## Structure
- Shared package `rx_ctrl_pkg` holds the state encodings and the magnitude-width helper localparam.
- Sub-module `err_mag_window` contains the saturating abs, the accumulator, the window counter and the threshold compare. It outputs `win_done`, `win_good` and `win_bad` as one-cycle pulses.
- The top level contains the FSM, the FLUSH and ACQ counters, and the miss counter.

## Test plan
Benches use FLUSH_CYC=4, ACQ_SYMS=16, LOG2_WIN=2, LOCK_THR=10, UNLOCK_THR=20, LOSS_WINDOWS=2, with strobes every 4 cycles.
- Reset, then `i_start` at cycle 10 → `o_flush` high in cycles 11–14. `o_state`=2 and step=0x010 at cycle 15. `o_locked`=0.
- 16 strobes in ACQ → `o_state`=3 and step=0x001 the cycle after the 16th strobe.
- TRACK with eI=2, eQ=-2 (m=4, acc=16 ≤ 40) → `o_locked`=1 after the first TRACK window end.
- Locked, then eI=eQ=15 (acc=120 > 80) for 2 windows → `o_locked`=0 and `o_state`=2 after the second window. One bad window followed by a good window → lock held.
- eI=-2048, eQ=0 → m=2047, no wrap.
- `i_freeze` high for 20 cycles in ACQ → `o_state`=4 and `o_lms_en`=0. Strobes are ignored, and the ACQ count resumes where it stopped. `i_start`+`i_freeze` together → FLUSH.
